hazard_stall_ctrl: RTL and testbench

- Counterpart to the EX-stage bypass logic in the 5-stage MIPS pipeline.
- The bypass logic consumes results that are already in flight. This block handles the cases that bypassing cannot cover: load-use hazards and ID-stage branch operands not yet produced.
- It drives PC/IF-ID write enables, inserts ID/EX bubbles, flushes IF/ID on taken branches, and honours an external multi-cycle freeze.
- A small FSM enforces multi-bubble stalls.

---
 rtl/hazard_stall_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Purpose:
//   Hazard-stall controller for the 5-stage MIPS pipeline. It covers the cases
//   that EX-stage bypassing cannot resolve:
//     - load-use hazards (LU);
//     - branch operands that the ID-stage comparator needs, where the operand
//       is produced by an ALU op still in EX (BA) or by a load in MEM (BL).
//   It stalls PC and IF/ID, inserts ID/EX bubbles, flushes IF/ID on taken
//   branches and honours an external multi-cycle freeze (ext_stall).
//   A small RUN/HOLD FSM extends a stall to two cycles when a branch in ID
//   depends on a load still in EX.
//
// Optional feature (macro HAZARD_STALL_PERF_EN):
//   When defined, stall_cycles counts the clock edges at which IDEXFlush or
//   Freeze is high (reset excluded) and wraps at 2^CNT_W. When undefined,
//   stall_cycles is tied to zero and no counter register exists.
//
// Ports:
//   clk, rst                       clock (rising edge), sync active-high reset
//   id_Rs, id_Rt                   source registers of the ID instruction
//   id_UsesRs, id_UsesRt           ID instruction actually reads Rs / Rt
//   id_IsBranch                    ID instruction is a branch compared in ID
//   exe_MemRead, exe_RegWrite      EX instruction is a load / writes a reg
//   exe_RegisterRd                 EX destination register
//   mem_MemRead, mem_RegisterRd    MEM instruction is a load / its destination
//   branch_taken                   ID branch resolved taken
//   ext_stall                      multi-cycle unit busy
//   PCWrite, IFIDWrite             PC / IF-ID register write enables
//   IDEXFlush                      load a bubble into ID/EX
//   IFIDFlush                      clear IF/ID (taken branch, or reset)
//   Freeze                         hold ID/EX, EX/MEM, MEM/WB
//   stall_cycles                   stall-cycle performance counter
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_Rs,
  input  logic [REG_W-1:0] id_Rt,
  input  logic             id_UsesRs,
  input  logic             id_UsesRt,
  input  logic             id_IsBranch,
  input  logic             exe_MemRead,
  input  logic             exe_RegWrite,
  input  logic [REG_W-1:0] exe_RegisterRd,
  input  logic             mem_MemRead,
  input  logic [REG_W-1:0] mem_RegisterRd,
  input  logic             branch_taken,
  input  logic             ext_stall,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXFlush,
  output logic             IFIDFlush,
  output logic             Freeze,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t     state, state_next;
  // Remaining HOLD cycles; only ever loaded with 1 today, width leaves room
  // for deeper stalls without reworking the decrement logic.
  logic [1:0] cnt, cnt_next;

  logic lu_hit, ba_hit, bl_hit;
  logic stall, need_two;

  // A producer register conflicts with the ID instruction only if it is not
  // $zero and the ID instruction really reads the matching operand.
  function automatic logic reg_match(input logic [REG_W-1:0] r);
    return (r != '0) &&
           (((r == id_Rs) && id_UsesRs) || ((r == id_Rt) && id_UsesRt));
  endfunction

  always_comb begin
    lu_hit   = exe_MemRead && reg_match(exe_RegisterRd);
    ba_hit   = id_IsBranch && exe_RegWrite && !exe_MemRead &&
               reg_match(exe_RegisterRd);
    bl_hit   = id_IsBranch && mem_MemRead && reg_match(mem_RegisterRd);
    stall    = lu_hit || ba_hit || bl_hit;
    // Only a branch waiting on a load in EX needs two bubbles; BA/BL need one,
    // so the maximum over all firing hazards reduces to this term.
    need_two = lu_hit && id_IsBranch;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the if/case tree can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IDEXFlush  = 1'b0;
    IFIDFlush  = branch_taken;
    Freeze     = 1'b0;

    if (ext_stall) begin
      // Freeze wins over everything: state and cnt are held, no bubble, and a
      // taken branch must not flush while the pipeline is frozen.
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IFIDFlush = 1'b0;
      Freeze    = 1'b1;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (stall) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
            IFIDFlush = 1'b0;
            if (need_two) begin
              state_next = ST_HOLD;
              cnt_next   = 2'd1;
            end
          end
        end
        ST_HOLD: begin
          // Hazard inputs are ignored here: the pipeline is committed to the
          // extra bubble regardless of what the stalled stages now show.
          PCWrite   = 1'b0;
          IFIDWrite = 1'b0;
          IDEXFlush = 1'b1;
          IFIDFlush = 1'b0;
          if (cnt <= 2'd1) begin
            state_next = ST_RUN;
            cnt_next   = 2'd0;
          end else begin
            cnt_next = cnt - 2'd1;
          end
        end
        default: begin
          state_next = ST_RUN;
          cnt_next   = 2'd0;
        end
      endcase
    end

    // Reset drives a clean bubble/flush into the front of the pipeline.
    if (rst) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IDEXFlush = 1'b1;
      IFIDFlush = 1'b1;
      Freeze    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

`ifdef HAZARD_STALL_PERF_EN
  // Wraps naturally at 2^CNT_W; IDEXFlush is forced high during reset, but
  // reset takes priority so those cycles are never counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (IDEXFlush || Freeze) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//
// Directed-vector bench for hazard_stall_ctrl. The driver applies one input
// vector per cycle just after the rising edge and pushes the hand-computed
// expected outputs into a scoreboard queue; a monitor pops and compares on the
// falling edge. Expected stall_cycles comes from a running count of the
// expected stall/freeze cycles (zero when HAZARD_STALL_PERF_EN is undefined).
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 32;

`ifdef HAZARD_STALL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Output bundle order: {PCWrite, IFIDWrite, IDEXFlush, IFIDFlush, Freeze}
  localparam logic [4:0] O_NORM  = 5'b11000;
  localparam logic [4:0] O_TAKEN = 5'b11010;
  localparam logic [4:0] O_STALL = 5'b00100;
  localparam logic [4:0] O_FRZ   = 5'b00001;
  localparam logic [4:0] O_RST   = 5'b00110;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] id_Rs, id_Rt, exe_RegisterRd, mem_RegisterRd;
  logic             id_UsesRs, id_UsesRt, id_IsBranch;
  logic             exe_MemRead, exe_RegWrite, mem_MemRead;
  logic             branch_taken, ext_stall;
  logic             PCWrite, IFIDWrite, IDEXFlush, IFIDFlush, Freeze;
  logic [CNT_W-1:0] stall_cycles;

  typedef struct {
    string            name;
    logic [4:0]       outs;
    logic [CNT_W-1:0] cnt;
    bit               chk_cnt;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned exp_cnt  = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_Rs          (id_Rs),
    .id_Rt          (id_Rt),
    .id_UsesRs      (id_UsesRs),
    .id_UsesRt      (id_UsesRt),
    .id_IsBranch    (id_IsBranch),
    .exe_MemRead    (exe_MemRead),
    .exe_RegWrite   (exe_RegWrite),
    .exe_RegisterRd (exe_RegisterRd),
    .mem_MemRead    (mem_MemRead),
    .mem_RegisterRd (mem_RegisterRd),
    .branch_taken   (branch_taken),
    .ext_stall      (ext_stall),
    .PCWrite        (PCWrite),
    .IFIDWrite      (IFIDWrite),
    .IDEXFlush      (IDEXFlush),
    .IFIDFlush      (IFIDFlush),
    .Freeze         (Freeze),
    .stall_cycles   (stall_cycles)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rst            = 1'b0;
    id_Rs          = '0;
    id_Rt          = '0;
    id_UsesRs      = 1'b0;
    id_UsesRt      = 1'b0;
    id_IsBranch    = 1'b0;
    exe_MemRead    = 1'b0;
    exe_RegWrite   = 1'b0;
    exe_RegisterRd = '0;
    mem_MemRead    = 1'b0;
    mem_RegisterRd = '0;
    branch_taken   = 1'b0;
    ext_stall      = 1'b0;
  endtask

  // Inputs are already applied (just after an edge); queue the expectation
  // for this cycle, then advance to just after the next edge.
  task automatic step(input string name, input logic [4:0] outs);
    exp_t e;
    e.name    = name;
    e.outs    = outs;
    e.cnt     = PERF ? CNT_W'(exp_cnt) : '0;
    e.chk_cnt = !rst;
    sb.push_back(e);
    if (rst) exp_cnt = 0;
    else if (outs[2] || outs[0]) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares whatever the driver queued for the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".outs"},
              32'({PCWrite, IFIDWrite, IDEXFlush, IFIDFlush, Freeze}),
              32'(e.outs));
        if (e.chk_cnt) check({e.name, ".stall_cycles"}, stall_cycles, e.cnt);
      end
    end
  end

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    idle(); rst = 1'b1;                                step("reset", O_RST);
    idle();                                            step("idle", O_NORM);

    // Load-use, single bubble, then load in MEM with non-branch consumer
    idle(); exe_MemRead = 1; exe_RegisterRd = 8; id_Rs = 8; id_UsesRs = 1;
                                                       step("lu", O_STALL);
    idle(); mem_MemRead = 1; mem_RegisterRd = 8; id_Rs = 8; id_UsesRs = 1;
                                                       step("lu_after", O_NORM);

    // Branch after load: RUN stall, HOLD stall, flush suppressed in both
    idle(); exe_MemRead = 1; exe_RegisterRd = 9; id_Rt = 9; id_UsesRt = 1;
    id_IsBranch = 1; branch_taken = 1;                 step("bl2_run", O_STALL);
    idle(); mem_MemRead = 1; mem_RegisterRd = 9; id_Rt = 9; id_UsesRt = 1;
    id_IsBranch = 1; branch_taken = 1;                 step("bl2_hold", O_STALL);
    idle(); id_Rt = 9; id_UsesRt = 1; id_IsBranch = 1; branch_taken = 1;
                                                       step("bl2_go", O_TAKEN);

    // Branch after ALU op: exactly one stall, then taken flush
    idle(); exe_RegWrite = 1; exe_RegisterRd = 4; id_Rs = 4; id_UsesRs = 1;
    id_IsBranch = 1;                                   step("ba", O_STALL);
    idle(); id_Rs = 4; id_UsesRs = 1; id_IsBranch = 1; branch_taken = 1;
                                                       step("ba_taken", O_TAKEN);

    // $zero and non-used operand never stall
    idle(); exe_MemRead = 1; exe_RegisterRd = 0; id_Rs = 0; id_UsesRs = 1;
                                                       step("zero_reg", O_NORM);
    idle(); exe_MemRead = 1; exe_RegisterRd = 5; id_Rt = 5; id_UsesRt = 0;
                                                       step("unused_rt", O_NORM);

    // ALU op in EX feeding a non-branch is left to bypassing
    idle(); exe_RegWrite = 1; exe_RegisterRd = 6; id_Rs = 6; id_UsesRs = 1;
                                                       step("alu_nobr", O_NORM);

    // Branch waiting on a load in MEM: one stall, stays in RUN
    idle(); id_IsBranch = 1; mem_MemRead = 1; mem_RegisterRd = 7; id_Rs = 7;
    id_UsesRs = 1;                                     step("bl1", O_STALL);
    idle();                                            step("bl1_after", O_NORM);

    // LU + BL together -> two bubbles; ext_stall for 3 cycles during HOLD
    idle(); id_IsBranch = 1; exe_MemRead = 1; exe_RegisterRd = 3; id_Rt = 3;
    id_UsesRt = 1; mem_MemRead = 1; mem_RegisterRd = 2; id_Rs = 2;
    id_UsesRs = 1;                                     step("lubl_run", O_STALL);
    for (int i = 0; i < 3; i++) begin
      idle(); ext_stall = 1; id_IsBranch = 1; branch_taken = 1;
      step($sformatf("hold_frz%0d", i), O_FRZ);
    end
    idle();                                            step("hold_rest", O_STALL);
    idle();                                            step("hold_done", O_NORM);

    // ext_stall in RUN outranks a live hazard and a taken branch
    idle(); ext_stall = 1; exe_MemRead = 1; exe_RegisterRd = 12; id_Rs = 12;
    id_UsesRs = 1; branch_taken = 1;                   step("run_frz", O_FRZ);
    idle(); exe_MemRead = 1; exe_RegisterRd = 12; id_Rs = 12; id_UsesRs = 1;
                                                       step("run_unfrz", O_STALL);

    // Reset mid-HOLD aborts the stall
    idle(); exe_MemRead = 1; exe_RegisterRd = 9; id_Rt = 9; id_UsesRt = 1;
    id_IsBranch = 1;                                   step("rh_run", O_STALL);
    idle(); rst = 1;                                   step("rh_rst", O_RST);
    idle();                                            step("rh_after", O_NORM);
    idle(); branch_taken = 1;                          step("rh_taken", O_TAKEN);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
